fetch: RTL and testbench

- IF stage of the 5-stage RV64 pipeline. Owns the PC and issues instruction requests on the instruction bus.
- Presents fetched instructions to decode as a data_fetch_t bundle (valid, raw_instr, pc_now).
- Consumes the branch/branch_target redirect that decode produces.
- Holds a one-entry skid buffer so memory responses are never lost under decode stall.

---
 rtl/fetch.sv | 143 ++++++++++++++
 tb/tb_fetch.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// IF stage: owns the PC, issues instruction-bus requests and hands {valid, instr, pc} to decode
// through a one-entry skid buffer. Define FETCH_PERF_CNT_EN to add the fetch_cnt output.
package fetch_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] raw_instr;
        logic [63:0] pc_now;
    } data_fetch_t;

    typedef enum logic {
        S_REQ     = 1'b0,
        S_DISCARD = 1'b1
    } fetch_state_e;
endpackage

module fetch
    import fetch_pkg::*;
#(
    parameter logic [63:0] PC_RESET = 64'h8000_0000
) (
    input  logic         clk,
    input  logic         reset,
    output logic         ireq_valid,
    output logic [63:0]  ireq_addr,
    input  logic         iresp_data_ok,
    input  logic [31:0]  iresp_data,
    input  logic         stall,
    input  logic         branch,
    input  logic [63:0]  branch_target,
    output data_fetch_t  data_f,
`ifdef FETCH_PERF_CNT_EN
    output logic [63:0]  fetch_cnt,
`endif
    output fetch_state_e dbg_state_o
);

    // Handshake: a request is live while ireq_valid=1; ireq_valid and ireq_addr hold
    // steady until the cycle that also has iresp_data_ok=1, which completes it.

    fetch_state_e state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic [63:0]  req_addr_q, req_addr_d;
    data_fetch_t  data_f_q, data_f_d;
    logic         skid_valid_q, skid_valid_d;
    logic [31:0]  skid_instr_q, skid_instr_d;
    logic [63:0]  skid_pc_q, skid_pc_d;
    logic         resp;
    logic         deliver;

    // In DISCARD the wrong-path request is still live and must keep its original address.
    assign ireq_valid  = !reset && ((state_q == S_DISCARD) || !skid_valid_q);
    assign ireq_addr   = (state_q == S_DISCARD) ? req_addr_q : pc_q;
    assign resp        = iresp_data_ok && ireq_valid;
    assign data_f      = data_f_q;
    assign dbg_state_o = state_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        data_f_d     = data_f_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        deliver      = 1'b0;

        if (branch) begin
            data_f_d.valid = 1'b0;
            skid_valid_d   = 1'b0;
            pc_d           = branch_target;
            if (state_q == S_REQ && ireq_valid && !iresp_data_ok) begin
                state_d    = S_DISCARD;
                req_addr_d = pc_q;
            end else if (state_q == S_DISCARD && resp) begin
                state_d = S_REQ;
            end
        end else if (state_q == S_DISCARD) begin
            if (resp) begin
                state_d = S_REQ;
            end
        end else begin
            if (data_f_q.valid && !stall) begin
                data_f_d.valid     = skid_valid_q;
                data_f_d.raw_instr = skid_instr_q;
                data_f_d.pc_now    = skid_pc_q;
                skid_valid_d       = 1'b0;
            end
            // A response can only arrive with the skid empty, so it never collides with a drain.
            if (resp) begin
                deliver = 1'b1;
                pc_d    = pc_q + 64'd4;
                if (!data_f_q.valid || !stall) begin
                    data_f_d.valid     = 1'b1;
                    data_f_d.raw_instr = iresp_data;
                    data_f_d.pc_now    = pc_q;
                end else begin
                    skid_valid_d = 1'b1;
                    skid_instr_d = iresp_data;
                    skid_pc_d    = pc_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_REQ;
            pc_q         <= PC_RESET;
            req_addr_q   <= '0;
            data_f_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            data_f_q     <= data_f_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [63:0] cnt_q, cnt_d;

    assign cnt_d     = deliver ? cnt_q + 64'd1 : cnt_q;
    assign fetch_cnt = cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_deliver;
    assign unused_deliver = deliver;
`endif

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: a bench-driven instruction bus, a scoreboard of expected
// {instr, pc} pairs checked as decode consumes data_f, and direct checks of the request side.
module tb_fetch;
    import fetch_pkg::*;

    logic         clk;
    logic         reset;
    logic         ireq_valid;
    logic [63:0]  ireq_addr;
    logic         iresp_data_ok;
    logic [31:0]  iresp_data;
    logic         stall;
    logic         branch;
    logic [63:0]  branch_target;
    data_fetch_t  data_f;
    fetch_state_e dbg_state;
`ifdef FETCH_PERF_CNT_EN
    logic [63:0]  fetch_cnt;
`endif

    logic [95:0] exp_q[$];
    int n_tests;
    int n_fail;
    int n_push;

    fetch dut (
        .clk          (clk),
        .reset        (reset),
        .ireq_valid   (ireq_valid),
        .ireq_addr    (ireq_addr),
        .iresp_data_ok(iresp_data_ok),
        .iresp_data   (iresp_data),
        .stall        (stall),
        .branch       (branch),
        .branch_target(branch_target),
        .data_f       (data_f),
`ifdef FETCH_PERF_CNT_EN
        .fetch_cnt    (fetch_cnt),
`endif
        .dbg_state_o  (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] instr_of(input logic [63:0] addr);
        return addr[31:0] ^ 32'h1357_9BDF ^ {addr[63:48], 16'h0};
    endfunction

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: decode consumes data_f at a posedge where valid=1, stall=0 and no redirect.
    // A redirect throws away whatever is held in data_f and the skid.
    always @(negedge clk) begin
        if (!reset) begin
            if (branch) begin
                exp_q.delete();
            end else if (data_f.valid && !stall) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_data_f", {data_f.raw_instr, data_f.pc_now}, 96'hx);
                end else begin
                    check("data_f", {data_f.raw_instr, data_f.pc_now}, exp_q.pop_front());
                end
            end
        end
    end

    // Driver: one bus cycle, entered and left at posedge+1 with stall/branch already set.
    task automatic bus_cycle(input bit ok, input bit exp_rv, input logic [63:0] exp_addr,
                             input bit push, input int exp_dv);
        #1;
        check("ireq_valid", {95'd0, ireq_valid}, {95'd0, exp_rv});
        if (exp_rv) check("ireq_addr", {32'd0, ireq_addr}, {32'd0, exp_addr});
        if (exp_dv >= 0) check("data_f_valid", {95'd0, data_f.valid}, {95'd0, exp_dv[0]});
        iresp_data_ok = ok;
        iresp_data    = instr_of(ireq_addr);
        if (push) begin
            exp_q.push_back({instr_of(exp_addr), exp_addr});
            n_push++;
        end
        @(posedge clk);
        #1;
        iresp_data_ok = 1'b0;
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        n_push        = 0;
        reset         = 1'b1;
        iresp_data_ok = 1'b0;
        iresp_data    = '0;
        stall         = 1'b0;
        branch        = 1'b0;
        branch_target = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ireq_valid", {95'd0, ireq_valid}, 96'd0);
        check("rst_data_f", {64'd0, data_f}, 96'd0);
        check("rst_state", {95'd0, dbg_state}, {95'd0, S_REQ});
        reset = 1'b0;

        // zero-latency bus, back-to-back
        bus_cycle(1, 1, 64'h8000_0000, 1, 0);
        bus_cycle(1, 1, 64'h8000_0004, 1, 1);
        bus_cycle(1, 1, 64'h8000_0008, 1, 1);
        // three-cycle latency
        bus_cycle(0, 1, 64'h8000_000C, 0, 1);
        bus_cycle(0, 1, 64'h8000_000C, 0, 0);
        bus_cycle(1, 1, 64'h8000_000C, 1, 0);
        bus_cycle(0, 1, 64'h8000_0010, 0, 1);
        bus_cycle(0, 1, 64'h8000_0010, 0, 0);
        bus_cycle(1, 1, 64'h8000_0010, 1, 0);

        // stall for four cycles: data_f frozen, skid full, no request
        stall = 1'b1;
        bus_cycle(1, 1, 64'h8000_0014, 1, 1);
        for (int i = 0; i < 3; i++) begin
            bus_cycle(0, 0, 64'h0, 0, 1);
            check("stall_pc_now", {32'd0, data_f.pc_now}, {32'd0, 64'h8000_0010});
        end
        stall = 1'b0;
        bus_cycle(0, 0, 64'h0, 0, 1);
        bus_cycle(1, 1, 64'h8000_0018, 1, 1);
        bus_cycle(0, 1, 64'h8000_001C, 0, 1);

        // redirect while request outstanding, second redirect inside DISCARD
        branch = 1'b1;
        branch_target = 64'h8000_00F0;
        bus_cycle(0, 1, 64'h8000_001C, 0, 0);
        branch = 1'b0;
        check("discard_state", {95'd0, dbg_state}, {95'd0, S_DISCARD});
        stall = 1'b1;
        branch = 1'b1;
        branch_target = 64'h8000_0100;
        bus_cycle(0, 1, 64'h8000_001C, 0, 0);
        branch = 1'b0;
        bus_cycle(1, 1, 64'h8000_001C, 0, 0);
        stall = 1'b0;
        check("discard_exit", {95'd0, dbg_state}, {95'd0, S_REQ});
        bus_cycle(1, 1, 64'h8000_0100, 1, 0);

        // redirect with stall and a full skid, then redirect together with data_ok
        stall = 1'b1;
        bus_cycle(1, 1, 64'h8000_0104, 1, 1);
        branch = 1'b1;
        branch_target = 64'h8000_0300;
        bus_cycle(0, 0, 64'h0, 0, 1);
        branch_target = 64'h8000_0400;
        bus_cycle(1, 1, 64'h8000_0300, 0, 0);
        branch = 1'b0;
        stall = 1'b0;
        check("same_cycle_state", {95'd0, dbg_state}, {95'd0, S_REQ});
        bus_cycle(1, 1, 64'h8000_0400, 1, 0);

        // PC wrap at 2^64
        bus_cycle(1, 1, 64'h8000_0404, 1, 1);
        branch = 1'b1;
        branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
        bus_cycle(1, 1, 64'h8000_0408, 0, 1);
        branch = 1'b0;
        bus_cycle(1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0);
        bus_cycle(1, 1, 64'h0000_0000_0000_0000, 1, 1);
        bus_cycle(0, 1, 64'h0000_0000_0000_0004, 0, 1);
        bus_cycle(0, 1, 64'h0000_0000_0000_0004, 0, 0);

        check("scoreboard_empty", 96'(exp_q.size()), 96'd0);
`ifdef FETCH_PERF_CNT_EN
        check("fetch_cnt", {32'd0, fetch_cnt}, 96'(n_push));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
